// File: rtl/regfile_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl_pkg
// Description : Shared sizes and FSM state encoding for the register file
//               dump sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_ctrl_pkg;

    localparam int RF_AW    = 3;
    localparam int RF_DW    = 16;
    localparam int RF_NREGS = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ,
        S_SEND = ST_SEND,
        S_DONE = ST_DONE
    } state_t;

endpackage : regfile_dump_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_dump_ctrl_next_set_idx.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl_next_set_idx
// Description : Combinational search for the lowest set mask bit at or above
//               (include_cur=1) or strictly above (include_cur=0) cur.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl_next_set_idx
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = RF_AW
) (
    input  logic [NREGS-1:0] mask,
    input  logic [AW-1:0]    cur,
    input  logic             include_cur,
    output logic [AW-1:0]    idx,
    output logic             found
);

    // Scan from the top down so the lowest qualifying bit is the last writer.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (include_cur && (i == int'(cur))))) begin
                idx   = AW'(i);
                found = 1'b1;
            end
        end
    end

endmodule : regfile_dump_ctrl_next_set_idx
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl
// Description : Read-side sequencer for the 8x16 register file. Walks the
//               registers selected by a mask, lowest index first, and streams
//               each word with its index over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NREGS-1:0] reg_mask,
    output logic [AW-1:0]    readnum,
    input  logic [DW-1:0]    rf_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [AW-1:0]    out_idx,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [NREGS-1:0] r_mask;

    logic [NREGS-1:0] w_sel_mask;
    logic [AW-1:0]    w_cur;
    logic             w_include_cur;
    logic [AW-1:0]    w_next_idx;
    logic             w_next_found;

    // In IDLE the search looks for the first index of the incoming mask;
    // otherwise it looks for the next index above the word just sent.
    always_comb begin
        w_sel_mask    = r_mask;
        w_cur         = out_idx;
        w_include_cur = 1'b0;
        if (r_state == S_IDLE) begin
            w_sel_mask    = reg_mask;
            w_cur         = '0;
            w_include_cur = 1'b1;
        end
    end

    regfile_dump_ctrl_next_set_idx #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_next_set_idx (
        .mask        (w_sel_mask),
        .cur         (w_cur),
        .include_cur (w_include_cur),
        .idx         (w_next_idx),
        .found       (w_next_found)
    );

    // Dump sequencer: IDLE -> (READ -> SEND)* -> DONE -> IDLE, all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            readnum   <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (w_next_found) begin
                            r_mask  <= reg_mask;
                            readnum <= w_next_idx;
                            busy    <= 1'b1;
                            r_state <= S_READ;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    out_data  <= rf_data;
                    out_idx   <= readnum;
                    out_valid <= 1'b1;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_next_found) begin
                            readnum <= w_next_idx;
                            r_state <= S_READ;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : regfile_dump_ctrl
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_ctrl
// Description : Self-checking bench for regfile_dump_ctrl with a behavioural
//               register file and an expected-word scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  reg_mask = '0;
    logic [2:0]  readnum;
    logic [15:0] rf_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;
    logic        done;

    logic [15:0] rf [8];
    logic [18:0] exp_q [$];

    int n_pass  = 0;
    int n_total = 0;

    assign rf_data = rf[readnum];

    always #5 clk = ~clk;

    regfile_dump_ctrl u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .reg_mask  (reg_mask),
        .readnum   (readnum),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if ({readnum, out_valid, out_idx, out_data, busy, done} !== 25'd0)
            $display("FAIL reset_state got=%h exp=0", {readnum, out_valid, out_idx, out_data, busy, done});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        bit seen_done = 0;
        logic [18:0] e;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 16'h1000 + 16'(i);
            exp_q.push_back({3'(i), 16'h1000 + 16'(i)});
        end
        out_ready = 1'b1;
        start = 1'b1; reg_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0; reg_mask = 8'h00;
        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            if (cyc == 1) begin
                n_total++;
                if ({busy, out_valid} !== 2'b10) $display("FAIL full_cyc1 busy/valid got=%b exp=10", {busy, out_valid});
                else n_pass++;
            end
            if (cyc == 2) begin
                n_total++;
                if (out_valid !== 1'b1) $display("FAIL full_first_valid got=%b exp=1", out_valid);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL full_extra_word got=%h", {out_idx, out_data});
                else begin
                    e = exp_q.pop_front();
                    if ({out_idx, out_data} !== e) $display("FAIL full_word got=%h exp=%h", {out_idx, out_data}, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                n_total++;
                if (cyc != 17 || busy !== 1'b0) $display("FAIL full_done_cycle got=%0d busy=%b exp=17 busy=0", cyc, busy);
                else n_pass++;
            end else @(negedge clk);
        end
        n_total++;
        if (!seen_done || exp_q.size() != 0) $display("FAIL full_complete done=%0d left=%0d exp done=1 left=0", seen_done, exp_q.size());
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_sparse();
        bit seen_done = 0;
        int words = 0;
        logic [18:0] e;
        rf[0] = 16'hAAAA; rf[2] = 16'h0042; rf[7] = 16'hFFFF;
        exp_q.push_back({3'd0, 16'hAAAA});
        exp_q.push_back({3'd2, 16'h0042});
        exp_q.push_back({3'd7, 16'hFFFF});
        out_ready = 1'b1;
        start = 1'b1; reg_mask = 8'b1000_0101;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            if (out_valid && out_ready) begin
                words++;
                n_total++;
                if (exp_q.size() == 0) $display("FAIL sparse_extra_word got=%h", {out_idx, out_data});
                else begin
                    e = exp_q.pop_front();
                    if ({out_idx, out_data} !== e) $display("FAIL sparse_word got=%h exp=%h", {out_idx, out_data}, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) seen_done = 1;
            else @(negedge clk);
        end
        n_total++;
        if (!seen_done || words != 3) $display("FAIL sparse_count got=%0d done=%0d exp=3 done=1", words, seen_done);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit seen_done = 0;
        int words = 0;
        int stall = 0;
        logic [18:0] held = '0;
        logic [18:0] e;
        rf[0] = 16'h0B0B; rf[1] = 16'h1C1C;
        exp_q.push_back({3'd0, 16'h0B0B});
        exp_q.push_back({3'd1, 16'h1C1C});
        out_ready = 1'b0;
        start = 1'b1; reg_mask = 8'h03;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
            if (out_valid) begin
                if (stall == 0) held = {out_idx, out_data};
                else begin
                    n_total++;
                    if ({out_idx, out_data} !== held) $display("FAIL bp_stable got=%h exp=%h", {out_idx, out_data}, held);
                    else n_pass++;
                end
                if (stall < 5) begin out_ready = 1'b0; stall++; end
                else out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                words++;
                stall = 0;
                n_total++;
                if (exp_q.size() == 0) $display("FAIL bp_extra_word got=%h", {out_idx, out_data});
                else begin
                    e = exp_q.pop_front();
                    if ({out_idx, out_data} !== e) $display("FAIL bp_word got=%h exp=%h", {out_idx, out_data}, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) seen_done = 1;
            else @(negedge clk);
        end
        n_total++;
        if (!seen_done || words != 2) $display("FAIL bp_count got=%0d done=%0d exp=2 done=1", words, seen_done);
        else n_pass++;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_and_ignored_start();
        int dones = 0;
        int words = 0;
        bit pulsed = 0;
        // Empty mask: DONE on the very next cycle, no word.
        start = 1'b1; reg_mask = 8'h00;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if ({done, busy, out_valid} !== 3'b100) $display("FAIL empty_done got=%b exp=100", {done, busy, out_valid});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done, out_valid} !== 2'b00) $display("FAIL empty_after got=%b exp=00", {done, out_valid});
        else n_pass++;
        // Start pulsed during SEND of a full dump is dropped.
        for (int i = 0; i < 8; i++) rf[i] = 16'h2000 + 16'(i);
        out_ready = 1'b1;
        start = 1'b1; reg_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            start = 1'b0;
            if (out_valid && !pulsed) begin start = 1'b1; reg_mask = 8'h01; pulsed = 1; end
            if (out_valid && out_ready) words++;
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        start = 1'b0;
        n_total++;
        if (words != 8 || dones != 1) $display("FAIL ignored_start words=%0d dones=%0d exp words=8 dones=1", words, dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        bit hit = 0;
        bit seen_done = 0;
        int dones = 0;
        logic [18:0] e;
        for (int i = 0; i < 8; i++) rf[i] = 16'h3000 + 16'(i);
        out_ready = 1'b1;
        start = 1'b1; reg_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
            if (out_valid && out_idx == 3'd3) begin out_ready = 1'b0; hit = 1; end
            else @(negedge clk);
        end
        n_total++;
        if (!hit) $display("FAIL rst_reach_idx3 got=0 exp=1");
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({readnum, out_valid, out_idx, out_data, busy, done} !== 25'd0)
            $display("FAIL rst_async got=%h exp=0", {readnum, out_valid, out_idx, out_data, busy, done});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_total++;
        if (dones != 0) $display("FAIL rst_no_done got=%0d exp=0", dones);
        else n_pass++;
        exp_q.push_back({3'd3, rf[3]});
        start = 1'b1; reg_mask = 8'h08;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen_done; cyc++) begin
            if (out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL rst_extra_word got=%h", {out_idx, out_data});
                else begin
                    e = exp_q.pop_front();
                    if ({out_idx, out_data} !== e) $display("FAIL rst_word got=%h exp=%h", {out_idx, out_data}, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) seen_done = 1;
            else @(negedge clk);
        end
        n_total++;
        if (!seen_done || exp_q.size() != 0) $display("FAIL rst_fresh_dump done=%0d left=%0d exp done=1 left=0", seen_done, exp_q.size());
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_live_read();
        bit seen_done = 0;
        bit wrote = 0;
        logic [18:0] e;
        rf[4] = 16'h4444; rf[5] = 16'h0000;
        exp_q.push_back({3'd4, 16'h4444});
        exp_q.push_back({3'd5, 16'h5555});
        out_ready = 1'b1;
        start = 1'b1; reg_mask = 8'h30;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 30 && !seen_done; cyc++) begin
            if (out_valid && out_idx == 3'd4 && !wrote) begin rf[5] = 16'h5555; wrote = 1; end
            if (out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL live_extra_word got=%h", {out_idx, out_data});
                else begin
                    e = exp_q.pop_front();
                    if ({out_idx, out_data} !== e) $display("FAIL live_word got=%h exp=%h", {out_idx, out_data}, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) seen_done = 1;
            else @(negedge clk);
        end
        n_total++;
        if (!seen_done || exp_q.size() != 0) $display("FAIL live_complete done=%0d left=%0d exp done=1 left=0", seen_done, exp_q.size());
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        test_reset();
        test_full_dump();
        test_sparse();
        test_backpressure();
        test_empty_and_ignored_start();
        test_reset_mid_dump();
        test_live_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_dump_ctrl
`default_nettype wire
